// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: issues fixed-latency word reads, buffers {pc, instr}
// in a small FIFO for decode, and flushes/refetches on a downstream redirect.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      i_datain,
   input  logic             imem_rvalid,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_pc,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      r_pc;
   logic [31:0]      r_req_pc;
   logic             r_inflight;
   logic             r_drop;

   logic             w_inflight;
   logic             w_push;
   logic             w_pop;
   logic [OCC_W-1:0] w_occ;
   logic [PTR_W-1:0] w_rd_ptr;
   logic             w_unused;

   // Issue only while buffered plus in-flight words leave room for the response.
   always_comb begin
      w_inflight = r_inflight & ~r_drop;
      w_occ      = OCC_W'(r_count) + OCC_W'(w_inflight);
      imem_req   = rst_n & ~redirect & (w_occ < OCC_W'(DEPTH));
      w_push     = imem_rvalid & ~r_drop;
      w_pop      = out_valid & out_ready;
   end

   // When empty, keep showing the most recently presented slot.
   assign out_valid  = (r_count != '0);
   assign w_rd_ptr   = out_valid ? r_head : (r_head - PTR_W'(1));
   assign out_instr  = r_mem[w_rd_ptr].instr;
   assign out_pc     = r_mem[w_rd_ptr].pc;
   assign fifo_count = r_count;
   assign imem_addr  = r_pc;
   assign w_unused   = ^redirect_pc[1:0];

   // Fetch PC, PC of the outstanding request, and response-drop tracking.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_inflight <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_inflight <= imem_req;
         r_drop     <= redirect;
         if (redirect) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
         end else if (imem_req) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
         end
      end
   end

   // FIFO storage; a redirect flushes and overrides any push or pop in that cycle.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else if (redirect) begin
         r_count <= '0;
         if (r_count != '0) begin
            r_head <= r_head + PTR_W'(1);
            r_tail <= r_head + PTR_W'(1);
         end
      end else begin
         if (w_push) begin
            r_mem[r_tail].pc    <= r_req_pc;
            r_mem[r_tail].instr <= i_datain;
            r_tail              <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // The issue rule must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clock) disable iff (!rst_n)
      !(w_push && !redirect && (r_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus a randomized run,
// all checked against a queue-based fetch/FIFO reference model.
module tb_ifetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic [31:0]      i_datain;
   logic             imem_rvalid;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [31:0]      out_pc;
   logic [CNT_W-1:0] fifo_count;

   int n_vec = 0;
   int n_err = 0;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .i_datain   (i_datain),
      .imem_rvalid(imem_rvalid),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .fifo_count (fifo_count)
   );

   always #5 clock = ~clock;

   // Instruction memory: one-cycle latency, word = address ^ KEY.
   always @(posedge clock) begin
      imem_rvalid <= imem_req;
      i_datain    <= imem_addr ^ KEY;
   end

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t             q[$];
   logic [31:0]      m_pc;
   logic [31:0]      m_pend_addr;
   bit               m_pend;
   bit               m_drop;
   logic             e_req;
   logic [31:0]      e_addr;
   logic             e_valid;
   logic [31:0]      e_pc;
   logic [31:0]      e_instr;
   logic [CNT_W-1:0] e_count;

   task automatic model_reset();
      q.delete();
      m_pc        = RESET_PC;
      m_pend      = 1'b0;
      m_pend_addr = '0;
      m_drop      = 1'b0;
   endtask

   // Expected outputs for the current cycle, given current inputs.
   task automatic model_eval();
      int infl;
      infl    = (m_pend && !m_drop) ? 1 : 0;
      e_req   = !redirect && ((q.size() + infl) < int'(DEPTH));
      e_addr  = m_pc;
      e_valid = (q.size() != 0);
      e_count = CNT_W'(q.size());
      if (e_valid) begin
         e_pc    = q[0].pc;
         e_instr = q[0].instr;
      end
   endtask

   // Apply this cycle's effects to the model, then move to the next negedge.
   task automatic model_commit();
      ent_t ne;
      if (!rst_n) begin
         model_reset();
      end else begin
         ne.pc    = m_pend_addr;
         ne.instr = m_pend_addr ^ KEY;
         if (redirect) begin
            q.delete();
         end else begin
            if (e_valid && out_ready) void'(q.pop_front());
            if (m_pend && !m_drop) q.push_back(ne);
         end
         m_pend      = e_req;
         m_pend_addr = m_pc;
         if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
         else if (e_req) m_pc = m_pc + 32'd4;
         m_drop = redirect;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      redirect  = 1'b0;
      out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: req=%b valid=%b, want 0 0", imem_req, out_valid);
      end
      n_vec++;
      if (fifo_count !== '0) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d want 0", fifo_count);
      end
      n_vec++;
      if (out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== RESET_PC) begin
         n_err++;
         $display("FAIL reset_data: pc=%h instr=%h addr=%h, want 0 0 %h", out_pc, out_instr, imem_addr, RESET_PC);
      end
      @(negedge clock);
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         out_ready = 1'b1;
         redirect  = 1'b0;
         #1;
         model_eval();
         n_vec++;
         if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
             (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
            n_err++;
            $display("FAIL stream c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
         end
         if (i < 12) begin
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
               n_err++;
               $display("FAIL stream_addr c%0d: req=%b addr=%h, want 1 %h", i, imem_req, imem_addr, 32'(4 * i));
            end
         end
         if (i >= 2 && i < 12) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * (i - 2)) || out_instr !== (32'(4 * (i - 2)) ^ KEY)) begin
               n_err++;
               $display("FAIL stream_head c%0d: v=%b pc=%h ins=%h, want 1 %h %h",
                        i, out_valid, out_pc, out_instr, 32'(4 * (i - 2)), 32'(4 * (i - 2)) ^ KEY);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_backpressure();
      int nreq = 0;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         redirect  = 1'b0;
         out_ready = (i == 8);
         #1;
         model_eval();
         n_vec++;
         if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
             (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
            n_err++;
            $display("FAIL backpressure c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
         end
         if (i == 6) begin
            n_vec++;
            if (fifo_count !== CNT_W'(4) || imem_req !== 1'b0) begin
               n_err++;
               $display("FAIL bp_full: cnt=%0d req=%b, want 4 0", fifo_count, imem_req);
            end
         end
         if (i == 9) begin
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || out_pc !== 32'h4) begin
               n_err++;
               $display("FAIL bp_resume: req=%b addr=%h head=%h, want 1 00000010 00000004", imem_req, imem_addr, out_pc);
            end
         end
         if (imem_req === 1'b1) nreq++;
         model_commit();
      end
      n_vec++;
      if (nreq != 5) begin
         n_err++;
         $display("FAIL bp_reqcount: got %0d want 5", nreq);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 14; i++) begin
         out_ready   = 1'b1;
         redirect    = (i == 6);
         redirect_pc = 32'h0000_0103;
         #1;
         model_eval();
         n_vec++;
         if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
             (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
            n_err++;
            $display("FAIL redirect c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
         end
         if (i == 6) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h10 || imem_req !== 1'b0) begin
               n_err++;
               $display("FAIL redir_at: v=%b pc=%h req=%b, want 1 00000010 0", out_valid, out_pc, imem_req);
            end
         end
         if (i == 7) begin
            n_vec++;
            if (fifo_count !== '0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
               n_err++;
               $display("FAIL redir_next: cnt=%0d req=%b addr=%h, want 0 1 00000100", fifo_count, imem_req, imem_addr);
            end
         end
         if (i == 8) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL redir_drop: valid=%b pc=%h, want valid 0", out_valid, out_pc);
            end
         end
         if (i == 9) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== (32'h100 ^ KEY)) begin
               n_err++;
               $display("FAIL redir_lat: v=%b pc=%h ins=%h, want 1 00000100 %h", out_valid, out_pc, out_instr, 32'h100 ^ KEY);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         out_ready   = 1'b1;
         redirect    = (i == 6) || (i == 7);
         redirect_pc = (i == 6) ? 32'h200 : 32'h300;
         #1;
         model_eval();
         n_vec++;
         if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
             (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
            n_err++;
            $display("FAIL b2b c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
         end
         if (i == 8) begin
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
               n_err++;
               $display("FAIL b2b_addr: req=%b addr=%h, want 1 00000300", imem_req, imem_addr);
            end
         end
         if (i == 9) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL b2b_early: valid=%b pc=%h, want valid 0", out_valid, out_pc);
            end
         end
         if (i == 10) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
               n_err++;
               $display("FAIL b2b_first: v=%b pc=%h, want 1 00000300", out_valid, out_pc);
            end
         end
         if (i >= 8) begin
            n_vec++;
            if (out_valid === 1'b1 && out_pc[31:8] === 24'h000002) begin
               n_err++;
               $display("FAIL b2b_stale c%0d: pc=%h, want no 0x2xx entry", i, out_pc);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_pop_push_redirect();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         out_ready   = (i >= 3);
         redirect    = (i == 4);
         redirect_pc = 32'h40;
         #1;
         model_eval();
         n_vec++;
         if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
             (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
            n_err++;
            $display("FAIL poppush c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
         end
         if (i == 3 || i == 4) begin
            n_vec++;
            if (fifo_count !== CNT_W'(2) || out_pc !== 32'(4 * (i - 3))) begin
               n_err++;
               $display("FAIL pp_count c%0d: cnt=%0d head=%h, want 2 %h", i, fifo_count, out_pc, 32'(4 * (i - 3)));
            end
         end
         if (i == 5) begin
            n_vec++;
            if (fifo_count !== '0 || out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL pp_flush: cnt=%0d valid=%b, want 0 0", fifo_count, out_valid);
            end
         end
         if (i == 7) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
               n_err++;
               $display("FAIL pp_refetch: v=%b pc=%h, want 1 00000040", out_valid, out_pc);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 12; i++) begin
         out_ready = 1'b1;
         redirect  = 1'b0;
         rst_n     = (i != 5);
         #1;
         if (!rst_n) begin
            n_vec++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0 || fifo_count !== '0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
               n_err++;
               $display("FAIL rstmid_async: req=%b v=%b cnt=%0d pc=%h ins=%h, want all 0",
                        imem_req, out_valid, fifo_count, out_pc, out_instr);
            end
         end else begin
            model_eval();
            n_vec++;
            if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
                (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
               n_err++;
               $display("FAIL rstmid c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                        i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
            end
         end
         if (i == 6) begin
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC || fifo_count !== '0) begin
               n_err++;
               $display("FAIL rstmid_restart: req=%b addr=%h cnt=%0d, want 1 %h 0", imem_req, imem_addr, fifo_count, RESET_PC);
            end
         end
         if (i == 7) begin
            n_vec++;
            if (out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL rstmid_pending: valid=%b pc=%h, want valid 0", out_valid, out_pc);
            end
         end
         if (i == 8) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
               n_err++;
               $display("FAIL rstmid_first: v=%b pc=%h, want 1 %h", out_valid, out_pc, RESET_PC);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         out_ready   = 1'b1;
         redirect    = (i == 3);
         redirect_pc = 32'hFFFF_FFF8;
         #1;
         model_eval();
         n_vec++;
         if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
             (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
            n_err++;
            $display("FAIL wrap c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                     i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
         end
         if (i >= 6 && i <= 8) begin
            want = 32'hFFFF_FFF8 + 32'(4 * (i - 6));
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== want || out_instr !== (want ^ KEY)) begin
               n_err++;
               $display("FAIL wrap_seq c%0d: v=%b pc=%h ins=%h, want 1 %h %h", i, out_valid, out_pc, out_instr, want, want ^ KEY);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_random();
      int phase;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         phase = (i / 200) % 3;
         rst_n = ($urandom_range(0, 399) != 0);
         redirect = ($urandom_range(0, 15) == 0);
         redirect_pc = $urandom();
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         case (phase)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = ($urandom_range(0, 7) == 0);
         endcase
         #1;
         if (!rst_n) begin
            n_vec++;
            if (imem_req !== 1'b0 || out_valid !== 1'b0 || fifo_count !== '0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
               n_err++;
               $display("FAIL random_rst c%0d: req=%b v=%b cnt=%0d pc=%h ins=%h, want all 0",
                        i, imem_req, out_valid, fifo_count, out_pc, out_instr);
            end
         end else begin
            model_eval();
            n_vec++;
            if (imem_req !== e_req || fifo_count !== e_count || out_valid !== e_valid ||
                (e_req && imem_addr !== e_addr) || (e_valid && (out_pc !== e_pc || out_instr !== e_instr))) begin
               n_err++;
               $display("FAIL random c%0d: got req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d exp req=%b addr=%h v=%b pc=%h ins=%h cnt=%0d",
                        i, imem_req, imem_addr, out_valid, out_pc, out_instr, fifo_count, e_req, e_addr, e_valid, e_pc, e_instr, e_count);
            end
         end
         model_commit();
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b0;
      model_reset();
      @(negedge clock);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_pop_push_redirect();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
